// File: rtl/mem_access_stage_if.sv
// Data-memory request/response bus between the MEM stage and data RAM.
// master: req/we/addr/wdata out, gnt/rvalid/rdata in; slave: mirrored.
interface mem_access_stage_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// MEM stage: issues loads/stores, stalls until done, registers writeback/redirect.
// Ports: clk, reset_n, EX/MEM inputs, mem (master bus), stall, wb_*, redirect_*, misaligned.
module mem_access_stage (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] pc_data,
  input  logic [31:0] rs2_data,
  input  logic [4:0]  rd_address,
  input  logic [31:0] alu_rd_result,
  input  logic        alu_rd_result_is_zero,
  input  logic [31:0] alu_pc_result,
  input  logic [1:0]  next_pc_src,
  input  logic        reg_write_data_src,
  input  logic        reg_wren,
  input  logic        ram_wren,
  mem_access_stage_if.master mem,
  output logic        stall,
  output logic        wb_wren,
  output logic [4:0]  wb_rd_address,
  output logic [31:0] wb_data,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        misaligned
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_t;

  state_t state, state_nxt;

  logic store, load, access, misal;
  logic done, req_c;
  logic is_jump;
  logic [31:0] wb_data_nxt;

  assign store  = ram_wren;
  assign load   = ~ram_wren & reg_write_data_src & reg_wren;
  assign access = store | load;
  assign misal  = access & (alu_rd_result[1:0] != 2'b00);

  assign is_jump = next_pc_src[1];

  always_comb begin
    state_nxt = state;
    req_c     = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (!access || misal) begin
          done = 1'b1;
        end else begin
          req_c = 1'b1;
          if (mem.mem_gnt) begin
            if (store) done = 1'b1;
            else state_nxt = WAIT;
          end else begin
            state_nxt = REQ;
          end
        end
      end
      REQ: begin
        req_c = 1'b1;
        if (mem.mem_gnt) begin
          if (store) begin
            done      = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (mem.mem_rvalid) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Held low during reset so upstream is not frozen by a dead request.
  assign mem.mem_req   = req_c & reset_n;
  assign stall         = ~done & reset_n;
  assign mem.mem_addr  = {alu_rd_result[31:2], 2'b00};
  assign mem.mem_we    = ram_wren;
  assign mem.mem_wdata = rs2_data;

  always_comb begin
    wb_data_nxt = alu_rd_result;
    if (load) wb_data_nxt = mem.mem_rdata;
    else if (is_jump) wb_data_nxt = pc_data + 32'd4;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_wren        <= 1'b0;
      wb_rd_address  <= 5'd0;
      wb_data        <= 32'd0;
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'd0;
      misaligned     <= 1'b0;
    end else if (done) begin
      wb_wren        <= reg_wren & (rd_address != 5'd0)
                        & ~store & ~misal;
      wb_rd_address  <= rd_address;
      wb_data        <= wb_data_nxt;
      redirect_valid <= ((next_pc_src == 2'd1) & alu_rd_result_is_zero)
                        | is_jump;
      redirect_pc    <= (next_pc_src == 2'd3)
                        ? {alu_rd_result[31:1], 1'b0}
                        : alu_pc_result;
      misaligned     <= misal;
    end else begin
      // Stalled edge: pulses stay single-cycle per instruction.
      wb_wren        <= 1'b0;
      redirect_valid <= 1'b0;
      misaligned     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage.
// Drives EX/MEM fields and the memory bus slave side; checks with assertions.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] pc_data;
  logic [31:0] rs2_data;
  logic [4:0]  rd_address;
  logic [31:0] alu_rd_result;
  logic        alu_rd_result_is_zero;
  logic [31:0] alu_pc_result;
  logic [1:0]  next_pc_src;
  logic        reg_write_data_src;
  logic        reg_wren;
  logic        ram_wren;
  logic        stall;
  logic        wb_wren;
  logic [4:0]  wb_rd_address;
  logic [31:0] wb_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        misaligned;

  int vecs = 0;
  int errs = 0;

  mem_access_stage_if mif ();

  mem_access_stage dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .pc_data               (pc_data),
    .rs2_data              (rs2_data),
    .rd_address            (rd_address),
    .alu_rd_result         (alu_rd_result),
    .alu_rd_result_is_zero (alu_rd_result_is_zero),
    .alu_pc_result         (alu_pc_result),
    .next_pc_src           (next_pc_src),
    .reg_write_data_src    (reg_write_data_src),
    .reg_wren              (reg_wren),
    .ram_wren              (ram_wren),
    .mem                   (mif.master),
    .stall                 (stall),
    .wb_wren               (wb_wren),
    .wb_rd_address         (wb_rd_address),
    .wb_data               (wb_data),
    .redirect_valid        (redirect_valid),
    .redirect_pc           (redirect_pc),
    .misaligned            (misaligned)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    pc_data               = 32'h0;
    rs2_data              = 32'h0;
    rd_address            = 5'd0;
    alu_rd_result         = 32'h0;
    alu_rd_result_is_zero = 1'b0;
    alu_pc_result         = 32'h0;
    next_pc_src           = 2'd0;
    reg_write_data_src    = 1'b0;
    reg_wren              = 1'b0;
    ram_wren              = 1'b0;
    mif.mem_gnt           = 1'b0;
    mif.mem_rvalid        = 1'b0;
    mif.mem_rdata         = 32'h0;
  endtask

  initial begin
    reset_n = 1'b0;
    nop();
    tick();
    tick();
    chk("rst_wb_wren", wb_wren, 0);
    chk("rst_wb_rd", wb_rd_address, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_redir_v", redirect_valid, 0);
    chk("rst_redir_pc", redirect_pc, 0);
    chk("rst_misal", misaligned, 0);
    chk("rst_req", mif.mem_req, 0);
    chk("rst_stall", stall, 0);
    reset_n = 1'b1;

    // ALU op
    tick();
    rd_address    = 5'd5;
    reg_wren      = 1'b1;
    alu_rd_result = 32'h1234;
    #1;
    chk("alu_stall", stall, 0);
    chk("alu_req", mif.mem_req, 0);
    tick();
    chk("alu_wren", wb_wren, 1);
    chk("alu_rd", wb_rd_address, 5);
    chk("alu_data", wb_data, 32'h1234);
    chk("alu_redir", redirect_valid, 0);
    nop();
    tick();
    chk("alu_pulse", wb_wren, 0);

    // Load 0x100: gnt after 2 cycles, rvalid after 3 more
    rd_address         = 5'd7;
    reg_wren           = 1'b1;
    reg_write_data_src = 1'b1;
    alu_rd_result      = 32'h100;
    #1;
    chk("ld0_req", mif.mem_req, 1);
    chk("ld0_stall", stall, 1);
    chk("ld0_addr", mif.mem_addr, 32'h100);
    chk("ld0_we", mif.mem_we, 0);
    tick();
    chk("ld1_wren", wb_wren, 0);
    mif.mem_rvalid = 1'b1;
    mif.mem_rdata  = 32'h11111111;
    #1;
    chk("ld1_req", mif.mem_req, 1);
    chk("ld1_stall", stall, 1);
    tick();
    mif.mem_rvalid = 1'b0;
    mif.mem_gnt    = 1'b1;
    #1;
    chk("ld2_req", mif.mem_req, 1);
    chk("ld2_stall", stall, 1);
    tick();
    mif.mem_gnt = 1'b0;
    #1;
    chk("ld3_req", mif.mem_req, 0);
    chk("ld3_stall", stall, 1);
    tick();
    chk("ld4_stall", stall, 1);
    chk("ld4_wren", wb_wren, 0);
    tick();
    mif.mem_rvalid = 1'b1;
    mif.mem_rdata  = 32'hDEADBEEF;
    #1;
    chk("ld5_stall", stall, 0);
    tick();
    chk("ld_wren", wb_wren, 1);
    chk("ld_rd", wb_rd_address, 7);
    chk("ld_data", wb_data, 32'hDEADBEEF);
    nop();
    tick();
    chk("ld_pulse", wb_wren, 0);

    // Store 0x104, also flagged as load: store wins
    ram_wren           = 1'b1;
    reg_wren           = 1'b1;
    reg_write_data_src = 1'b1;
    rd_address         = 5'd3;
    alu_rd_result      = 32'h104;
    rs2_data           = 32'hA5A5A5A5;
    mif.mem_gnt        = 1'b1;
    #1;
    chk("st_req", mif.mem_req, 1);
    chk("st_we", mif.mem_we, 1);
    chk("st_wdata", mif.mem_wdata, 32'hA5A5A5A5);
    chk("st_addr", mif.mem_addr, 32'h104);
    chk("st_stall", stall, 0);
    tick();
    nop();
    chk("st_wren", wb_wren, 0);

    // Branch taken / not taken
    next_pc_src           = 2'd1;
    alu_rd_result_is_zero = 1'b1;
    alu_pc_result         = 32'h80;
    tick();
    chk("br_t_v", redirect_valid, 1);
    chk("br_t_pc", redirect_pc, 32'h80);
    alu_rd_result_is_zero = 1'b0;
    alu_pc_result         = 32'h90;
    tick();
    chk("br_nt_v", redirect_valid, 0);

    // jalr
    next_pc_src   = 2'd3;
    alu_rd_result = 32'h203;
    alu_pc_result = 32'h500;
    pc_data       = 32'h1000;
    rd_address    = 5'd1;
    reg_wren      = 1'b1;
    tick();
    chk("jalr_v", redirect_valid, 1);
    chk("jalr_pc", redirect_pc, 32'h202);
    chk("jalr_data", wb_data, 32'h1004);
    chk("jalr_wren", wb_wren, 1);

    // jal with wrapping link address
    next_pc_src   = 2'd2;
    alu_rd_result = 32'h203;
    alu_pc_result = 32'h40;
    pc_data       = 32'hFFFFFFFC;
    rd_address    = 5'd2;
    tick();
    chk("jal_v", redirect_valid, 1);
    chk("jal_pc", redirect_pc, 32'h40);
    chk("jal_wrap", wb_data, 32'h0);
    nop();

    // Misaligned load
    rd_address         = 5'd4;
    reg_wren           = 1'b1;
    reg_write_data_src = 1'b1;
    alu_rd_result      = 32'h102;
    mif.mem_gnt        = 1'b1;
    #1;
    chk("mis_req", mif.mem_req, 0);
    chk("mis_stall", stall, 0);
    tick();
    nop();
    chk("mis_pulse", misaligned, 1);
    chk("mis_wren", wb_wren, 0);
    tick();
    chk("mis_clear", misaligned, 0);

    // Load to x0
    reg_wren           = 1'b1;
    reg_write_data_src = 1'b1;
    alu_rd_result      = 32'h200;
    mif.mem_gnt        = 1'b1;
    #1;
    chk("x0_stall", stall, 1);
    tick();
    mif.mem_gnt    = 1'b0;
    mif.mem_rvalid = 1'b1;
    mif.mem_rdata  = 32'h12345678;
    tick();
    chk("x0_wren", wb_wren, 0);
    chk("x0_data", wb_data, 32'h12345678);
    nop();

    // Reset while waiting for load data
    rd_address         = 5'd6;
    reg_wren           = 1'b1;
    reg_write_data_src = 1'b1;
    alu_rd_result      = 32'h300;
    mif.mem_gnt        = 1'b1;
    tick();
    mif.mem_gnt = 1'b0;
    #1;
    chk("wt_req", mif.mem_req, 0);
    chk("wt_stall", stall, 1);
    reset_n = 1'b0;
    #1;
    chk("rw_stall", stall, 0);
    chk("rw_req", mif.mem_req, 0);
    chk("rw_wren", wb_wren, 0);
    tick();
    reset_n        = 1'b1;
    mif.mem_rvalid = 1'b1;
    mif.mem_rdata  = 32'hBAD0BAD0;
    #1;
    chk("late_req", mif.mem_req, 1);
    chk("late_stall", stall, 1);
    tick();
    chk("late_wren", wb_wren, 0);
    nop();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
